// File: rtl/qam_pkg.sv
// Shared types and constants for the QAM demodulator sequencing controller.
package qam_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2
  } state_t;

  localparam int SAMPLE_W  = 8;
  localparam int CARRIER_W = 8;
  localparam int PROD_W    = 16;

  // Symbol word layout: I (sine branch) in the upper bit, Q (cosine) below.
  localparam int SYM_W     = 2;
  localparam int SYM_I_BIT = 1;
  localparam int SYM_Q_BIT = 0;

endpackage

// File: rtl/qam_demod_ctrl_if.sv
// Decided-symbol valid/ready channel between the demodulator and its consumer.
interface qam_demod_ctrl_if;
  import qam_pkg::*;

  logic [SYM_W-1:0] sym_data;
  logic             sym_valid;
  logic             sym_ready;

  modport master (output sym_data, output sym_valid, input sym_ready);
  modport slave  (input sym_data, input sym_valid, output sym_ready);

endinterface

// File: rtl/qam_demod_ctrl_integrate_dump.sv
// One demodulator branch: carrier product, integrate over a symbol, dump and
// slice the sign of the completed sum.
module integrate_dump
  import qam_pkg::*;
#(
  parameter int ACC_W = 20
) (
  input  logic                        clk,
  input  logic                        vld_p0,
  input  logic                        dump_p0,
  input  logic signed [SAMPLE_W-1:0]  sample,
  input  logic signed [CARRIER_W-1:0] carrier,
  output logic                        dec
);

  logic signed [PROD_W-1:0] prod_p0;
  logic signed [ACC_W-1:0]  prod_ext_p0;
  logic signed [ACC_W-1:0]  sum_p0;
  logic signed [ACC_W-1:0]  acc_p1;

  // Strictly positive: a zero sum decides 0.
  function automatic logic slice_pos(input logic signed [ACC_W-1:0] s);
    return !s[ACC_W-1] && (s != '0);
  endfunction

  // p0: full-precision product folded into the running sum
  assign prod_p0     = PROD_W'(sample) * PROD_W'(carrier);
  assign prod_ext_p0 = {{(ACC_W-PROD_W){prod_p0[PROD_W-1]}}, prod_p0};
  assign sum_p0      = acc_p1 + prod_ext_p0;
  assign dec         = slice_pos(sum_p0);

  // p1: accumulator; idle cycles and symbol boundaries reload it to zero
  always_ff @(posedge clk) begin
    if (!vld_p0 || dump_p0) acc_p1 <= '0;
    else                    acc_p1 <= sum_p0;
  end

endmodule

// File: rtl/qam_demod_ctrl.sv
// QAM demodulator sequencer: carrier LUT addressing, settle/run FSM, I/Q
// integrate-and-dump branches and a one-entry symbol output register.
module qam_demod_ctrl
  import qam_pkg::*;
#(
  parameter int SAMPLES_PER_SYM = 16,
  parameter int LUT_DEPTH       = 16,
  parameter int SETTLE_SYMS     = 2,
  parameter int ACC_W           = 20
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic signed [SAMPLE_W-1:0]     input_signal,
  input  logic signed [CARRIER_W-1:0]    sin_in,
  input  logic signed [CARRIER_W-1:0]    cos_in,
  output logic [$clog2(LUT_DEPTH)-1:0]   lut_addr,
  qam_demod_ctrl_if.master               sym_if,
  output logic                           overrun,
  output logic                           busy,
  output logic [15:0]                    sym_count
);

  localparam int CNT_W       = $clog2(SAMPLES_PER_SYM);
  localparam int SET_W       = (SETTLE_SYMS > 1) ? $clog2(SETTLE_SYMS) : 1;
  localparam int SETTLE_LAST = (SETTLE_SYMS > 0) ? SETTLE_SYMS - 1 : 0;
  localparam logic [CNT_W-1:0] SAMP_LAST = CNT_W'(SAMPLES_PER_SYM - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] samp_cnt;
  logic [SET_W-1:0] settle_cnt;
  logic             vld_p0;
  logic             last_p0;
  logic             offer_p0;
  logic             load_p0;
  logic             dec_i, dec_q;
  logic [SYM_W-1:0] dec_word;

  // A sample is consumed only while active and still enabled; dropping en
  // abandons the partial symbol on the same edge.
  assign vld_p0  = (state != IDLE) && en;
  assign last_p0 = (samp_cnt == SAMP_LAST);

  always_comb begin
    state_n  = state;
    offer_p0 = 1'b0;
    busy     = (state != IDLE);
    unique case (state)
      IDLE:   if (en) state_n = (SETTLE_SYMS == 0) ? RUN : SETTLE;
      SETTLE: begin
        if (!en) state_n = IDLE;
        else if (last_p0 && (settle_cnt == SET_W'(SETTLE_LAST))) state_n = RUN;
      end
      RUN: begin
        if (!en) state_n = IDLE;
        offer_p0 = vld_p0 && last_p0;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst || !vld_p0) begin
      lut_addr   <= '0;
      samp_cnt   <= '0;
      settle_cnt <= '0;
    end else begin
      lut_addr <= lut_addr + 1'b1;
      samp_cnt <= last_p0 ? '0 : samp_cnt + 1'b1;
      if ((state == SETTLE) && last_p0) settle_cnt <= settle_cnt + 1'b1;
    end
  end

  integrate_dump #(.ACC_W(ACC_W)) u_branch_i (
    .clk     (clk),
    .vld_p0  (vld_p0),
    .dump_p0 (last_p0),
    .sample  (input_signal),
    .carrier (sin_in),
    .dec     (dec_i)
  );

  integrate_dump #(.ACC_W(ACC_W)) u_branch_q (
    .clk     (clk),
    .vld_p0  (vld_p0),
    .dump_p0 (last_p0),
    .sample  (input_signal),
    .carrier (cos_in),
    .dec     (dec_q)
  );

  always_comb begin
    dec_word            = '0;
    dec_word[SYM_I_BIT] = dec_i;
    dec_word[SYM_Q_BIT] = dec_q;
  end

  // p1: output register; a concurrent accept frees the slot for a new load
  assign load_p0 = offer_p0 && (!sym_if.sym_valid || sym_if.sym_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      sym_if.sym_data  <= '0;
      sym_if.sym_valid <= 1'b0;
      overrun          <= 1'b0;
      sym_count        <= '0;
    end else begin
      if (load_p0) begin
        sym_if.sym_data  <= dec_word;
        sym_if.sym_valid <= 1'b1;
        sym_count        <= sym_count + 16'd1;
      end else if (sym_if.sym_valid && sym_if.sym_ready) begin
        sym_if.sym_valid <= 1'b0;
      end
      if (offer_p0 && !load_p0) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_qam_demod_ctrl.sv
// Randomised scoreboard bench for qam_demod_ctrl against a sample-count model.
module tb_qam_demod_ctrl;
  import qam_pkg::*;

  localparam int SPS    = 16;
  localparam int LUTD   = 16;
  localparam int SETTLE = 2;
  localparam int ACCW   = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, en;
  logic signed [7:0] input_signal, sin_in, cos_in;
  logic [3:0]        lut_addr;
  logic              overrun, busy;
  logic [15:0]       sym_count;

  qam_demod_ctrl_if sym_if ();

  qam_demod_ctrl #(
    .SAMPLES_PER_SYM (SPS),
    .LUT_DEPTH       (LUTD),
    .SETTLE_SYMS     (SETTLE),
    .ACC_W           (ACCW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .input_signal (input_signal),
    .sin_in       (sin_in),
    .cos_in       (cos_in),
    .lut_addr     (lut_addr),
    .sym_if       (sym_if),
    .overrun      (overrun),
    .busy         (busy),
    .sym_count    (sym_count)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [1:0] exp_q[$];

  // Reference model: samples consumed since start decide everything.
  bit m_run, m_valid, m_ovr, m_data_zero;
  int m_nsamp, m_acc_i, m_acc_q, m_count;
  int sin_tab[LUTD];
  int cos_tab[LUTD];

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit e, input int x, input int s, input int c,
                            input bit r, input bit rs);
    bit offer = 1'b0;
    bit load  = 1'b0;
    bit accept;
    bit [1:0] d = 2'b00;
    if (rs) begin
      m_run = 0; m_nsamp = 0; m_acc_i = 0; m_acc_q = 0;
      m_valid = 0; m_ovr = 0; m_count = 0; m_data_zero = 1;
      exp_q.delete();
      return;
    end
    accept = m_valid && r;
    if (m_run && e) begin
      m_acc_i += x * s;
      m_acc_q += x * c;
      m_nsamp++;
      if (m_nsamp % SPS == 0) begin
        if (m_nsamp / SPS > SETTLE) begin
          offer = 1'b1;
          d = {m_acc_i > 0, m_acc_q > 0};
        end
        m_acc_i = 0; m_acc_q = 0;
      end
    end else if (m_run) begin
      m_run = 0; m_nsamp = 0; m_acc_i = 0; m_acc_q = 0;
    end else if (e) begin
      m_run = 1; m_nsamp = 0;
    end
    if (offer) begin
      if (!m_valid || r) begin
        load = 1'b1;
        m_valid = 1;
        m_data_zero = 0;
        m_count = (m_count + 1) % 65536;
        exp_q.push_back(d);
      end else begin
        m_ovr = 1;
      end
    end
    if (!load && accept) m_valid = 0;
  endtask

  task automatic check_outputs();
    chk("busy", busy, m_run);
    chk("lut_addr", lut_addr, m_nsamp % LUTD);
    chk("sym_valid", sym_if.sym_valid, m_valid);
    chk("overrun", overrun, m_ovr);
    chk("sym_count", sym_count, m_count);
    if (m_data_zero) chk("sym_data_reset", sym_if.sym_data, 0);
  endtask

  // Called just after a falling edge; returns just after the next one.
  task automatic cycle(input bit e, input int x, input int s, input int c,
                       input bit r, input bit rs = 1'b0);
    check_outputs();
    rst = rs; en = e;
    input_signal = 8'(x); sin_in = 8'(s); cos_in = 8'(c);
    sym_if.sym_ready = r;
    model_step(e, x, s, c, r, rs);
    @(negedge clk);
  endtask

  function automatic int rnd8();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  task automatic do_reset();
    repeat (3) cycle(1'b1, rnd8(), rnd8(), rnd8(), 1'($urandom_range(0, 1)), 1'b1);
  endtask

  // Runs constant inputs until sym_valid appears; returns edges after start.
  task automatic wait_first(input int x, input int s, input int c, input bit r,
                            output int lat);
    lat = -1;
    for (int i = 1; i <= 100 && lat < 0; i++) begin
      cycle(1'b1, x, s, c, r);
      if (sym_if.sym_valid) lat = i;
    end
  endtask

  // Scoreboard monitor: each accepted symbol is matched against the model.
  always @(negedge clk) begin
    logic [1:0] exp_d;
    #2;
    if (!rst && sym_if.sym_valid && sym_if.sym_ready) begin
      if (exp_q.size() == 0) chk("sb_underflow", 0, 1);
      else begin
        exp_d = exp_q.pop_front();
        chk("sym_data", sym_if.sym_data, exp_d);
      end
    end
  end

  initial begin
    int lat;
    bit e_rnd;
    rst = 1'b1; en = 1'b0; input_signal = '0; sin_in = '0; cos_in = '0;
    sym_if.sym_ready = 1'b0;
    model_step(1'b0, 0, 0, 0, 1'b0, 1'b1);
    @(negedge clk);

    // Reset dominates en=1 with random inputs.
    repeat (4) cycle(1'b1, rnd8(), rnd8(), rnd8(), 1'b1, 1'b1);
    chk("rst_busy", busy, 0);
    chk("rst_lut_addr", lut_addr, 0);
    chk("rst_sym_valid", sym_if.sym_valid, 0);
    chk("rst_sym_data", sym_if.sym_data, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_sym_count", sym_count, 0);

    // Constant carriers, consumer always ready.
    do_reset();
    cycle(1'b1, 64, 64, -64, 1'b1);
    wait_first(64, 64, -64, 1'b1, lat);
    chk("first_latency", lat, (SETTLE + 1) * SPS);
    chk("first_sym_data", sym_if.sym_data, 2);
    chk("first_sym_count", sym_count, 1);
    repeat (48) cycle(1'b1, 64, 64, -64, 1'b1);
    chk("steady_sym_count", sym_count, 4);

    // Backpressure: hold the first symbol, drop the next two.
    do_reset();
    cycle(1'b1, 64, 64, -64, 1'b0);
    wait_first(64, 64, -64, 1'b0, lat);
    chk("bp_latency", lat, (SETTLE + 1) * SPS);
    repeat (40) cycle(1'b1, 64, 64, -64, 1'b0);
    chk("bp_overrun", overrun, 1);
    chk("bp_sym_count", sym_count, 1);
    chk("bp_held_data", sym_if.sym_data, 2);
    for (int i = 0; i < 32 && (m_nsamp % SPS) != SPS - 1; i++)
      cycle(1'b1, 64, 64, -64, 1'b0);
    cycle(1'b1, 64, 64, -64, 1'b1);
    chk("bp_nobubble_valid", sym_if.sym_valid, 1);
    chk("bp_nobubble_count", sym_count, 2);
    repeat (40) cycle(1'b1, 64, 64, -64, 1'b1);

    // Abort during the first RUN symbol, then restart.
    do_reset();
    cycle(1'b1, 64, 64, -64, 1'b1);
    repeat (SETTLE * SPS + 7) cycle(1'b1, 64, 64, -64, 1'b1);
    cycle(1'b0, 64, 64, -64, 1'b1);
    chk("abort_busy", busy, 0);
    chk("abort_lut_addr", lut_addr, 0);
    chk("abort_sym_valid", sym_if.sym_valid, 0);
    repeat (3) cycle(1'b0, 64, 64, -64, 1'b1);
    cycle(1'b1, 64, 64, -64, 1'b1);
    wait_first(64, 64, -64, 1'b1, lat);
    chk("restart_latency", lat, (SETTLE + 1) * SPS);

    // Zero input: every decision is 00.
    do_reset();
    cycle(1'b1, 0, rnd8(), rnd8(), 1'b1);
    for (int i = 0; i < 112; i++) begin
      cycle(1'b1, 0, rnd8(), rnd8(), 1'b1);
      if (sym_if.sym_valid) chk("zero_in_data", sym_if.sym_data, 0);
    end
    chk("zero_in_count", sym_count, 5);

    // Alternating +/-127 against a constant sine carrier sums to exactly zero.
    do_reset();
    cycle(1'b1, 127, 127, rnd8(), 1'b1);
    for (int i = 0; i < 96; i++) begin
      cycle(1'b1, (i % 2) ? 127 : -127, 127, rnd8(), 1'b1);
      if (sym_if.sym_valid) chk("alt_i_bit", sym_if.sym_data[1], 0);
    end

    // Random samples, random carrier LUT, random backpressure and aborts.
    for (int k = 0; k < LUTD; k++) begin
      sin_tab[k] = rnd8();
      cos_tab[k] = rnd8();
    end
    do_reset();
    e_rnd = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if (e_rnd) e_rnd = ($urandom_range(0, 199) != 0);
      else       e_rnd = ($urandom_range(0, 3) == 0);
      cycle(e_rnd, rnd8(), sin_tab[m_nsamp % LUTD], cos_tab[m_nsamp % LUTD],
            ($urandom_range(0, 3) != 0));
    end
    repeat (4) cycle(1'b0, 0, 0, 0, 1'b1);
    #3;
    chk("sb_leftover", exp_q.size(), m_valid);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
